// File: rtl/booth_mult_seq_pkg.sv
// mult_pkg: shared types and sizing helpers for the sequential Booth multiplier.
//   state_t      - FSM state encoding (IDLE, RUN, DONE)
//   iter_count() - number of Booth steps for a given operand width
//   cnt_width()  - bits needed by the iteration counter for a given width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands are extended by one bit so signed and unsigned share the datapath,
  // hence one extra step beyond the operand width.
  function automatic int iter_count(input int width);
    return width + 1;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 2);

endpackage

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: start/done handshake and operand/result bus of the multiplier.
//   start, is_signed, a, b : request side (control unit -> multiplier)
//   busy, done, hi, lo     : status and HI/LO result (multiplier -> datapath)
// Modports: master = control unit / datapath, slave = multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/booth_mult_seq_booth_step.sv
// booth_step: one combinational radix-2 Booth iteration on (WIDTH+1)-bit operands.
//   acc_i/acc_o   : WIDTH+2-bit upper accumulator (one guard bit, so add/sub never overflows)
//   mplr_i/mplr_o : WIDTH+1-bit multiplier, shifted right each step
//   qm1_i/qm1_o   : Booth residual bit Q-1
//   mcand_i       : WIDTH+1-bit extended multiplicand
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] acc_i,
  input  logic [WIDTH:0]   mplr_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   mcand_i,
  output logic [WIDTH+1:0] acc_o,
  output logic [WIDTH:0]   mplr_o,
  output logic             qm1_o
);

  logic [WIDTH+1:0] mcand_ext;
  logic [WIDTH+1:0] sum;

  always_comb begin
    mcand_ext = {mcand_i[WIDTH], mcand_i};
    case ({mplr_i[0], qm1_i})
      2'b01:   sum = acc_i + mcand_ext;
      2'b10:   sum = acc_i - mcand_ext;
      default: sum = acc_i;
    endcase
    // Arithmetic right shift of {acc, mplr, qm1} as one long word.
    acc_o  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    mplr_o = {sum[0], mplr_i[WIDTH:1]};
    qm1_o  = mplr_i[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier for mult/multu.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of booth_mult_seq_if (start/is_signed/a/b in, busy/done/hi/lo out)
// One Booth step per cycle for WIDTH+1 cycles; the product lands in HI/LO on the
// RUN->DONE edge and is held there until the next completion or reset.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating Booth steps, busy=1
// DONE  | hi/lo just updated, done=1; start here launches the next operation
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  booth_mult_seq_if.slave bus
);

  localparam int              ITER     = iter_count(WIDTH);
  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           state_q, state_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH:0]   mplr_q, mplr_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH+1:0] step_acc;
  logic [WIDTH:0]   step_mplr;
  logic             step_qm1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .qm1_i   (qm1_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .mplr_o  (step_mplr),
    .qm1_o   (step_qm1)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      RUN: begin
        acc_d  = step_acc;
        mplr_d = step_mplr;
        qm1_d  = step_qm1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          // Low 2*WIDTH bits of the 2*(WIDTH+1)-bit product {acc[WIDTH:0], mplr}.
          hi_d    = {step_acc[WIDTH-2:0], step_mplr[WIDTH]};
          lo_d    = step_mplr[WIDTH-1:0];
        end
      end
      default: begin
        // IDLE and DONE both fall back to IDLE unless a new request arrives.
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          mcand_d = {bus.is_signed & bus.a[WIDTH-1], bus.a};
          mplr_d  = {bus.is_signed & bus.b[WIDTH-1], bus.b};
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mplr_q  <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(32)) bus32 ();
  booth_mult_seq_if #(.WIDTH(8))  bus8 ();

  booth_mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int checks = 0;
  int errors = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] model8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = sgn ? {{8{a[7]}}, a} : {8'b0, a};
    eb = sgn ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  // Drives a request for one edge, pushes the expected product, then scrambles
  // the operand inputs so any late sampling would corrupt the result.
  task automatic start32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    bus32.start     = 1'b1;
    bus32.is_signed = sgn;
    bus32.a         = a;
    bus32.b         = b;
    q32.push_back(model32(sgn, a, b));
    @(posedge clk); #1;
    bus32.start     = 1'b0;
    bus32.is_signed = ~sgn;
    bus32.a         = $urandom;
    bus32.b         = $urandom;
  endtask

  task automatic start8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    bus8.start     = 1'b1;
    bus8.is_signed = sgn;
    bus8.a         = a;
    bus8.b         = b;
    q8.push_back(model8(sgn, a, b));
    @(posedge clk); #1;
    bus8.start     = 1'b0;
    bus8.is_signed = ~sgn;
    bus8.a         = 8'($urandom);
    bus8.b         = 8'($urandom);
  endtask

  task automatic wait_done32(input int budget, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus32.done !== 1'b1 && lat < budget);
  endtask

  task automatic wait_done8(input int budget, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus8.done !== 1'b1 && lat < budget);
  endtask

  task automatic pop_chk32(input string tag);
    if (q32.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed result with empty scoreboard, required a queued entry", tag);
    end else begin
      chk(tag, {bus32.hi, bus32.lo}, q32.pop_front());
    end
  endtask

  task automatic pop_chk8(input string tag);
    if (q8.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed result with empty scoreboard, required a queued entry", tag);
    end else begin
      chk(tag, 64'({bus8.hi, bus8.lo}), 64'(q8.pop_front()));
    end
  endtask

  task automatic op32(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int lat;
    start32(sgn, a, b);
    chk({tag, " busy"}, 64'(bus32.busy), 64'd1);
    wait_done32(40, lat);
    chk({tag, " latency"}, 64'(lat), 64'd33);
    pop_chk32(tag);
  endtask

  task automatic op8(input string tag, input bit sgn, input logic [7:0] a, input logic [7:0] b);
    int lat;
    start8(sgn, a, b);
    wait_done8(20, lat);
    chk({tag, " latency"}, 64'(lat), 64'd9);
    pop_chk8(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int done_seen;

    reset = 1'b1;
    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus32.busy), 64'd0);
    chk("reset done", 64'(bus32.done), 64'd0);
    chk("reset hilo", {bus32.hi, bus32.lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    op32("s -3x7", 1'b1, 32'hFFFF_FFFD, 32'd7);
    chk("s -3x7 const", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    op32("s minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("s minxmin const", {bus32.hi, bus32.lo}, 64'h4000_0000_0000_0000);
    op32("u ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("u ffxff const", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);
    op32("s ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("s ffxff const", {bus32.hi, bus32.lo}, 64'h0000_0000_0000_0001);
    op32("s max x min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    op32("u a5 x 3c", 1'b0, 32'hA5A5_A5A5, 32'h3C3C_C3C3);
    for (int i = 0; i < 4; i++) begin
      op32("random", 1'($urandom), $urandom, $urandom);
    end

    op8("w8 s 80x7f", 1'b1, 8'h80, 8'h7F);
    chk("w8 s 80x7f const", 64'({bus8.hi, bus8.lo}), 64'h0000_0000_0000_C080);
    op8("w8 u ffxff", 1'b0, 8'hFF, 8'hFF);
    op8("w8 s 80x80", 1'b1, 8'h80, 8'h80);
    op8("w8 s ffx01", 1'b1, 8'hFF, 8'h01);

    // Ignored start mid-operation, then back-to-back start in DONE.
    op32("u 1x1", 1'b0, 32'd1, 32'd1);
    start32(1'b0, 32'd5, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    chk("hold mid-op", {bus32.hi, bus32.lo}, 64'd1);
    bus32.start = 1'b1; bus32.a = 32'd100; bus32.b = 32'd100; bus32.is_signed = 1'b0;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    chk("busy after ignored start", 64'(bus32.busy), 64'd1);
    chk("hold after ignored start", {bus32.hi, bus32.lo}, 64'd1);
    wait_done32(40, lat);
    chk("5x6 latency", 64'(lat + 10), 64'd33);
    pop_chk32("u 5x6");
    chk("5x6 const", {bus32.hi, bus32.lo}, 64'd30);
    start32(1'b0, 32'd2, 32'd2);
    chk("b2b done cleared", 64'(bus32.done), 64'd0);
    chk("b2b busy", 64'(bus32.busy), 64'd1);
    wait_done32(40, lat);
    chk("b2b done spacing", 64'(lat + 1), 64'd34);
    pop_chk32("u 2x2");
    chk("2x2 const", {bus32.hi, bus32.lo}, 64'd4);

    // Reset at cycle 15 of an operation aborts it without a done pulse.
    start32(1'b1, 32'd12345, 32'hFFFF_FFF9);
    repeat (14) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(q32.pop_front());
    chk("abort busy", 64'(bus32.busy), 64'd0);
    chk("abort done", 64'(bus32.done), 64'd0);
    chk("abort hilo", {bus32.hi, bus32.lo}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) done_seen++;
    end
    chk("abort no activity", 64'(done_seen), 64'd0);
    op32("after abort", 1'b1, 32'hFFFF_FF00, 32'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier for the CPU datapath. It serves both the signed (`mult`) and unsigned (`multu`) instructions. A start/done handshake lets the control unit stall until the result is ready. On completion the 2·WIDTH-bit product is written into the HI/LO result registers; the datapath's `mfhi` and `mflo` moves then read it.

## Interface
- `WIDTH`, default 32: operand width in bits; legal values are ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only when `busy`=0.
- `is_signed`  in  1  1 selects two's-complement operands, 0 selects unsigned; sampled with `start`.
- `a`  in  WIDTH  multiplicand; sampled with `start`.
- `b`  in  WIDTH  multiplier (the Booth-scanned operand); sampled with `start`.
- `busy`  out  1  high while iterating.
- `done`  out  1  single-cycle pulse when `hi`/`lo` have just been updated.
- `hi`  out  WIDTH  upper half of the product.
- `lo`  out  WIDTH  lower half of the product.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE.

## Operation
- FSM with three states: IDLE, RUN and DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE when the iteration counter reaches ITER−1.
  - DONE → RUN when `start`=1; otherwise DONE → IDLE.
- Operand capture, on the edge where `start` is accepted:
  - Both operands are extended to WIDTH+1 bits: sign-extended if `is_signed`=1, zero-extended if 0.
  - Accumulator cleared; Booth residual bit Q₋₁ = 0; counter = 0.
- Each RUN cycle performs one Booth step on the extended operands:
  - Examine {multiplier LSB, Q₋₁}.
  - 01: add the multiplicand to the upper accumulator.
  - 10: subtract the multiplicand from the upper accumulator.
  - 00 or 11: no add.
  - Then arithmetic-shift the whole {accumulator, multiplier, Q₋₁} right by 1.
- ITER = WIDTH+1 steps.
  - The accumulator is WIDTH+2 bits wide, so the add/sub never overflows.
  - The most-negative operand (e.g. 0x8000_0000) needs no special-case negation.
- Result: the low 2·WIDTH bits of the 2·(WIDTH+1)-bit product.
  - They are written to {`hi`,`lo`} on the RUN→DONE edge; `done`=1 during DONE.
- `hi`/`lo` hold their value until the next completion or `reset`; they are never written mid-operation.
- `start` while `busy`=1 is ignored; the in-flight operation continues unaffected.
- `start` in DONE is accepted, so back-to-back operations are possible with no idle cycle.
- `reset` at any time:
  - Returns the FSM to IDLE and clears `hi`/`lo`/`busy`/`done`.
  - The partial result is discarded and no `done` pulse is emitted.
  - `reset` has priority over `start` in the same cycle.

## Timing
- Edge 0 samples `start`=1; `busy`=1 from edge 0 to edge ITER.
- `done`=1 and new `hi`/`lo` are visible from edge ITER to edge ITER+1. For WIDTH=32 this is 33 cycles after acceptance.
- Back-to-back: with `start`=1 during DONE, the next `done` comes ITER+1 edges after the previous one.
- Changes on `a`/`b`/`is_signed` after acceptance have no effect.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package `mult_pkg`:
  - state enum {IDLE, RUN, DONE};
  - function `iter_count(width)` = width+1;
  - constant for the counter width, $clog2(WIDTH+2).
- Sub-module `booth_step`, combinational and parametrised by WIDTH:
  - inputs: accumulator, multiplier, Q₋₁ and multiplicand;
  - outputs: the shifted next accumulator, multiplier and Q₋₁;
  - instantiated once and iterated by the top-level FSM.
- Top level holds: FSM, counter, operand/accumulator registers, and the HI/LO registers.

## Test plan
- WIDTH=32, signed, a=−3 (0xFFFF_FFFD), b=7 → `done` at cycle 33; `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB.
- WIDTH=32, signed, a=b=0x8000_0000 → `hi`=0x4000_0000, `lo`=0x0000_0000.
- WIDTH=32, a=b=0xFFFF_FFFF:
  - unsigned → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001;
  - signed → `hi`=0x0000_0000, `lo`=0x0000_0001.
- WIDTH=8, signed, a=0x80, b=0x7F → `hi`=0xC0, `lo`=0x80, `done` at cycle 9.
- Start 5×6, then pulse `start` with other operands at cycle 10 → ignored; `hi`:`lo`=30.
  - Back-to-back start in DONE with 2×2 → 4 at exactly 34 cycles later.
- Assert `reset` at cycle 15 of an operation → `busy`=0, `hi`=`lo`=0, no `done` pulse.
  - A fresh start afterwards completes correctly.
